mc_control: RTL and testbench



---
 rtl/mips_defs.sv | 39 +++
 rtl/alu_op_decode.sv | 19 +
 rtl/mc_control.sv | 121 ++++++++++++
 tb/tb_mc_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// mips_defs: shared state, opcode, ALU op and alu_src_b encodings for the multicycle MIPS control.
package mips_defs;
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_HALT     = 4'd10
   } state_t;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_ADDI = 4'b0110;
   localparam logic [3:0] OP_LW   = 4'b0111;
   localparam logic [3:0] OP_SW   = 4'b1000;
   localparam logic [3:0] OP_BEQ  = 4'b1001;
   localparam logic [3:0] OP_BNE  = 4'b1010;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [1:0] SRC_B_REG = 2'b00;
   localparam logic [1:0] SRC_B_ONE = 2'b01;
   localparam logic [1:0] SRC_B_IMM = 2'b11;
   function automatic logic is_rtype(input logic [3:0] op);
      return op <= OP_SLT;
   endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps an R-type opcode to its ALU op; anything else gives AND (0000).
module alu_op_decode
   import mips_defs::*;
(
   input  logic [3:0] opcode,
   output logic [3:0] alu_op
);
   always_comb begin
      case (opcode)
         OP_ADD:  alu_op = ALU_ADD;
         OP_SUB:  alu_op = ALU_SUB;
         OP_AND:  alu_op = ALU_AND;
         OP_OR:   alu_op = ALU_OR;
         OP_NOR:  alu_op = ALU_NOR;
         OP_SLT:  alu_op = ALU_SLT;
         default: alu_op = 4'b0000;
      endcase
   end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle fetch/decode/execute/memory/writeback sequencer for the 16-bit MIPS datapath.
module mc_control
   import mips_defs::*;
#(
   parameter logic [1:0] PC_INC_SEL = 2'b01
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_src,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_op,
   output logic       halted
);
   state_t state, state_nxt;
   logic [3:0] r_op;

   alu_op_decode u_dec (.opcode(opcode), .alu_op(r_op));

   always_ff @(posedge clk)
      state <= rst ? S_FETCH : state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_nxt = is_rtype(opcode) ? S_EXEC_R :
                                 opcode == OP_ADDI ? S_EXEC_I :
                                 (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                                 (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH : S_HALT;
         S_EXEC_R:   state_nxt = S_WB_ALU;
         S_EXEC_I:   state_nxt = S_WB_ALU;
         S_MEM_ADDR: state_nxt = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_nxt = mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
         S_WB_ALU:   state_nxt = S_FETCH;
         S_WB_MEM:   state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_FETCH;
      endcase
   end

   // Outputs decode the registered state; rst masks everything so no write leaks during reset.
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 4'b0000;
      halted     = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               alu_src_b = PC_INC_SEL;
               alu_op    = ALU_ADD;
            end
            S_DECODE: begin
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_src_b = SRC_B_REG;
               alu_op    = r_op;
            end
            S_EXEC_I, S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_WB_ALU: begin
               reg_write = 1'b1;
               reg_dst   = is_rtype(opcode);
            end
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_src_b = SRC_B_REG;
               alu_op    = ALU_SUB;
               pc_src    = 1'b1;
               pc_write  = opcode == OP_BEQ ? zero : ~zero;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: per-instruction cycle scripts built from the opcode rules, replayed against mc_control.
module tb_mc_control;
   logic clk = 1'b0;
   logic rst, zero, mem_ready;
   logic [3:0] opcode;
   logic pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
   logic reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
   logic [1:0] alu_src_b;
   logic [3:0] alu_op;

   always #5 clk = ~clk;

   mc_control #(.PC_INC_SEL(2'b01)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .halted(halted)
   );

   // Bit map of e: 16 pc_write .. 7 alu_src_a, 6:5 alu_src_b, 4:1 alu_op, 0 halted.
   typedef struct packed {
      logic        r;
      logic        mr;
      logic        z;
      logic [3:0]  op;
      logic [16:0] e;
   } cyc_t;

   cyc_t q[$];
   int vectors = 0;
   int errors = 0;
   logic [3:0] r_alu [0:5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

   wire [16:0] act = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted};

   function automatic logic [16:0] vec(input logic pw, ps, irw, mrd, mwr, iod, rw, rd, m2r,
                                       sa, input logic [1:0] sb, input logic [3:0] aop,
                                       input logic h);
      return {pw, ps, irw, mrd, mwr, iod, rw, rd, m2r, sa, sb, aop, h};
   endfunction

   task automatic push(input logic r, mr, z, input logic [3:0] op, input logic [16:0] e);
      q.push_back('{r: r, mr: mr, z: z, op: op, e: e});
   endtask

   task automatic push_rst();
      push(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 17'd0);
   endtask

   task automatic build(input logic [3:0] op, input int fw, input int mw, input logic z);
      logic lw;
      lw = op == 4'b0111;
      for (int i = 0; i < fw; i++)
         push(1'b0, 1'b0, 1'($urandom), 4'($urandom),
              vec(0,0,0,1,0,0,0,0,0,0,2'b01,4'b0010,0));
      push(1'b0, 1'b1, 1'($urandom), 4'($urandom), vec(1,0,1,1,0,0,0,0,0,0,2'b01,4'b0010,0));
      push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,0,0,0,0,2'b11,4'b0010,0));
      if (op <= 4'd5) begin
         push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,0,0,0,1,2'b00,r_alu[op],0));
         push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,1,1,0,0,2'b00,4'b0000,0));
      end else if (op == 4'd6) begin
         push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,0,0,0,1,2'b11,4'b0010,0));
         push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,1,0,0,0,2'b00,4'b0000,0));
      end else if (op == 4'd7 || op == 4'd8) begin
         push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,0,0,0,1,2'b11,4'b0010,0));
         for (int i = 0; i <= mw; i++)
            push(1'b0, i == mw, 1'($urandom), op, vec(0,0,0,lw,!lw,1,0,0,0,0,2'b00,4'b0000,0));
         if (lw)
            push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,1,0,1,0,2'b00,4'b0000,0));
      end else if (op == 4'd9 || op == 4'd10) begin
         push(1'b0, 1'($urandom), z, op,
              vec(op == 4'd9 ? z : !z,1,0,0,0,0,0,0,0,1,2'b00,4'b0110,0));
      end else begin
         for (int i = 0; i < 12; i++)
            push(1'b0, 1'($urandom), 1'($urandom), op, vec(0,0,0,0,0,0,0,0,0,0,2'b00,4'b0000,1));
         push_rst();
      end
   endtask

   task automatic cut_rst(input int k);
      if (k < q.size()) begin
         while (q.size() > k) void'(q.pop_back());
         push_rst();
      end
   endtask

   task automatic pin(input string name, input logic [16:0] got, input logic [16:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL model %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic run();
      foreach (q[i]) begin
         @(posedge clk);
         #1;
         rst = q[i].r;
         mem_ready = q[i].mr;
         zero = q[i].z;
         opcode = q[i].op;
         @(negedge clk);
         vectors++;
         if (act !== q[i].e) begin
            errors++;
            $display("FAIL cycle%0d t=%0t op=%b rst=%b got=%05h exp=%05h", i, $time, q[i].op,
                     q[i].r, act, q[i].e);
         end
      end
      q.delete();
   endtask

   initial begin
      logic [3:0] op;
      rst = 1'b1;
      mem_ready = 1'b0;
      zero = 1'b0;
      opcode = 4'd0;
      push_rst();
      push_rst();
      run();
      build(4'b0000, 0, 0, 1'b0);
      pin("add_len", 17'(q.size()), 17'd4);
      pin("add_aluop", 17'(q[2].e[4:1]), 17'b0010);
      pin("add_wb", 17'({q[3].e[10], q[3].e[9]}), 17'b11);
      run();
      build(4'b0111, 0, 2, 1'b0);
      pin("lw_len", 17'(q.size()), 17'd7);
      pin("lw_m2r", 17'(q[6].e[8]), 17'd1);
      run();
      build(4'b1000, 0, 0, 1'b0);
      pin("sw_len", 17'(q.size()), 17'd4);
      run();
      build(4'b1001, 0, 0, 1'b1);
      pin("beq_len", 17'(q.size()), 17'd3);
      pin("beq_br", 17'({q[2].e[16], q[2].e[15], q[2].e[4:1]}), 17'b110110);
      run();
      build(4'b1010, 0, 0, 1'b1);
      pin("bne_br", 17'({q[2].e[16], q[2].e[15], q[2].e[4:1]}), 17'b010110);
      run();
      build(4'b0000, 3, 0, 1'b0);
      pin("fetch_wait_len", 17'(q.size()), 17'd7);
      run();
      build(4'b1101, 0, 0, 1'b0);
      pin("halt_flag", 17'(q[2].e), 17'd1);
      run();
      build(4'b1000, 0, 3, 1'b0);
      cut_rst(4);
      run();
      for (int n = 0; n < 400; n++) begin
         op = 4'($urandom_range(0, 11));
         if (op == 4'd11) op = 4'($urandom_range(11, 15));
         build(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
         if ($urandom_range(0, 9) == 0) cut_rst($urandom_range(0, 8));
         run();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
